// File: rtl/ask_demod_rx.sv
// On-off-keyed ASK receiver: rectify, integrate-and-dump per bit,
// UART-style framing (start=carrier, 8 data MSB first, stop=no carrier).
module ask_demod_rx #(
    parameter int ADC_W  = 8,
    parameter int SPB    = 64,
    parameter int AMP_TH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy,
    output logic             carrier_det
);

    localparam int MW  = ADC_W - 1;
    localparam int CW  = $clog2(SPB);
    localparam int AW  = MW + CW;
    localparam int ETH = (AMP_TH * SPB) >> 1;

    localparam logic [MW-1:0] TH_M  = MW'(AMP_TH);
    localparam logic [AW-1:0] ETH_A = AW'(ETH);
    localparam logic [CW-1:0] LAST  = CW'(SPB - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [ADC_W-1:0] s;
    logic [ADC_W-1:0] abs_full;
    logic [MW-1:0]    mag_n;
    logic [MW-1:0]    mag;
    logic             mag_v;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_sum;
    logic [CW-1:0]    cnt;
    logic [2:0]       bitidx;
    logic [7:0]       sreg;
    logic             bit_d;
    logic             last;

    assign s = {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]};

    // full-scale negative has no positive twin; clamp to max magnitude
    always_comb begin
        abs_full = s[ADC_W-1] ? (~s + ADC_W'(1)) : s;
        mag_n    = abs_full[ADC_W-1] ? {MW{1'b1}} : abs_full[MW-1:0];
    end

    assign acc_sum = acc + AW'(mag);
    assign bit_d   = (acc_sum >= ETH_A);
    assign last    = (cnt == LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag         <= '0;
            mag_v       <= 1'b0;
            carrier_det <= 1'b0;
        end else begin
            mag_v <= adc_valid;
            if (adc_valid) mag <= mag_n;
            if (mag_v) carrier_det <= (mag >= TH_M);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            bitidx     <= '0;
            sreg       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (mag_v) begin
                unique case (state)
                    IDLE: begin
                        if (mag >= TH_M) begin
                            acc    <= AW'(mag);
                            cnt    <= CW'(1);
                            bitidx <= '0;
                            state  <= START;
                        end
                    end
                    START: begin
                        if (last) begin
                            acc   <= '0;
                            cnt   <= '0;
                            state <= bit_d ? DATA : IDLE;
                        end else begin
                            acc <= acc_sum;
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (last) begin
                            acc    <= '0;
                            cnt    <= '0;
                            sreg   <= {sreg[6:0], bit_d};
                            bitidx <= bitidx + 3'd1;
                            if (bitidx == 3'd7) state <= STOP;
                        end else begin
                            acc <= acc_sum;
                            cnt <= cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        if (last) begin
                            acc      <= '0;
                            cnt      <= '0;
                            data_out <= sreg;
                            if (bit_d) frame_err  <= 1'b1;
                            else       data_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            acc <= acc_sum;
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ask_demod_rx.sv
// Directed bench for ask_demod_rx with a scoreboard of expected frames.
module tb_ask_demod_rx;

    localparam int SPB = 64;

    typedef struct {
        logic [7:0] d;
        bit         err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] adc_data = 8'h80;
    logic       adc_valid = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic       carrier_det;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic prev_p = 1'b0;

    ask_demod_rx #(.ADC_W(8), .SPB(SPB), .AMP_TH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .carrier_det(carrier_det)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic smp(input logic [7:0] v, input int gap);
        adc_data  = v;
        adc_valid = 1'b1;
        @(negedge clk);
        adc_valid = 1'b0;
        adc_data  = 8'h80;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_idle(input int n);
        repeat (n) smp(8'd128, 0);
    endtask

    task automatic send_bit(input bit b, input int gap, input bit sat);
        logic [7:0] v;
        for (int i = 0; i < SPB; i++) begin
            v = b ? ((i % 2 == 1) ? 8'd28 : 8'd228) : 8'd128;
            if (sat && i == 0) v = 8'h00;
            smp(v, gap);
            if (sat && i == 0)
                chk("sat_carrier_det", 16'(carrier_det), 16'd1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop,
                              input int gap, input bit sat);
        exp_t e;
        e.d   = d;
        e.err = stop;
        exp_q.push_back(e);
        send_bit(1'b1, gap, sat);
        for (int k = 7; k >= 0; k--) send_bit(d[k], gap, 1'b0);
        send_bit(stop, gap, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (data_valid === 1'b1 || frame_err === 1'b1)) begin
            chk("pulse_width", 16'(prev_p), 16'd0);
            chk("dv_fe_excl", 16'(data_valid & frame_err), 16'd0);
            chk("frame_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_data_out", 16'(data_out), 16'(e.d));
                chk("sb_data_valid", 16'(data_valid), 16'(!e.err));
                chk("sb_frame_err", 16'(frame_err), 16'(e.err));
            end
        end
        prev_p = (data_valid === 1'b1) || (frame_err === 1'b1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data_out", 16'(data_out), 16'h00);
        chk("rst_data_valid", 16'(data_valid), 16'd0);
        chk("rst_frame_err", 16'(frame_err), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_carrier_det", 16'(carrier_det), 16'd0);
        rst_n = 1'b1;
        send_idle(5);

        send_frame(8'hA5, 1'b0, 0, 1'b0);
        chk("a5_dv_early", 16'(data_valid), 16'd0);
        @(negedge clk);
        chk("a5_dv_on_time", 16'(data_valid), 16'd1);
        chk("a5_fe", 16'(frame_err), 16'd0);
        @(negedge clk);
        chk("a5_dv_after", 16'(data_valid), 16'd0);
        chk("a5_busy_idle", 16'(busy), 16'd0);
        send_idle(8);

        smp(8'd228, 0);
        send_idle(2);
        chk("glitch_busy_start", 16'(busy), 16'd1);
        send_idle(61);
        chk("glitch_busy_pre", 16'(busy), 16'd1);
        send_idle(1);
        chk("glitch_busy_done", 16'(busy), 16'd0);
        chk("glitch_carrier_det", 16'(carrier_det), 16'd0);
        chk("glitch_data_hold", 16'(data_out), 16'hA5);
        send_idle(8);

        send_frame(8'h3C, 1'b1, 0, 1'b0);
        send_idle(8);
        chk("err_data_out", 16'(data_out), 16'h3C);

        send_frame(8'h81, 1'b0, 2, 1'b1);
        send_idle(8);
        chk("gap_data_out", 16'(data_out), 16'h81);

        repeat (5) send_bit(1'b1, 0, 1'b0);
        chk("mid_busy", 16'(busy), 16'd1);
        chk("mid_carrier_det", 16'(carrier_det), 16'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_data_out", 16'(data_out), 16'h00);
        chk("arst_data_valid", 16'(data_valid), 16'd0);
        chk("arst_frame_err", 16'(frame_err), 16'd0);
        chk("arst_busy", 16'(busy), 16'd0);
        chk("arst_carrier_det", 16'(carrier_det), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_idle(5);

        send_frame(8'h5A, 1'b0, 0, 1'b0);
        send_idle(8);
        chk("post_rst_data_out", 16'(data_out), 16'h5A);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
